// File: rtl/memory_island_bank_arbiter.sv
// Per-bank arbiter between narrow and wide request paths of the memory island.
// Wide requests claim a whole bank group atomically; responses are steered back via a latency-matched ownership pipe.
module memory_island_bank_arbiter #(
  parameter int unsigned NumNarrowBanks     = 8,
  parameter int unsigned WideToNarrowFactor = 4,
  parameter int unsigned PayloadWidth       = 110,
  parameter int unsigned DataWidth          = 64,
  parameter int unsigned BankLatency        = 1,
  parameter int unsigned ArbMode            = 3,
  parameter int unsigned MaxStall           = 4
) (
  input  logic                                                clk_i,
  input  logic                                                rst_i,
  input  logic [NumNarrowBanks-1:0]                           narrow_q_valid_i,
  input  logic [NumNarrowBanks-1:0][PayloadWidth-1:0]         narrow_q_i,
  output logic [NumNarrowBanks-1:0]                           narrow_q_ready_o,
  input  logic [NumNarrowBanks/WideToNarrowFactor-1:0]        wide_q_valid_i,
  input  logic [NumNarrowBanks-1:0][PayloadWidth-1:0]         wide_q_i,
  output logic [NumNarrowBanks/WideToNarrowFactor-1:0]        wide_q_ready_o,
  output logic [NumNarrowBanks-1:0]                           bank_q_valid_o,
  output logic [NumNarrowBanks-1:0][PayloadWidth-1:0]         bank_q_o,
  input  logic [NumNarrowBanks-1:0][DataWidth-1:0]            bank_p_data_i,
  output logic [NumNarrowBanks-1:0]                           narrow_p_valid_o,
  output logic [NumNarrowBanks-1:0][DataWidth-1:0]            narrow_p_data_o,
  output logic [NumNarrowBanks/WideToNarrowFactor-1:0]        wide_p_valid_o,
  output logic [NumNarrowBanks-1:0][DataWidth-1:0]            wide_p_data_o
);

  localparam int unsigned NB = NumNarrowBanks;
  localparam int unsigned F  = WideToNarrowFactor;
  localparam int unsigned NG = NumNarrowBanks / WideToNarrowFactor;
  localparam int unsigned SW = 8;
  localparam logic [SW-1:0] StallMax = SW'(MaxStall);

  logic [NG-1:0]                 contested;
  logic [NG-1:0]                 wide_win;
  logic [NG-1:0]                 wide_gnt;
  logic [NG-1:0]                 rr_q;
  logic [NG-1:0][SW-1:0]         stall_q;
  logic [BankLatency-1:0][NG-1:0] own_wide_q;
  logic [BankLatency-1:0][NB-1:0] own_mask_q;

  // Per-group winner selection and bank request steering.
  always_comb begin : arbitrate
    contested        = '0;
    wide_win         = '0;
    wide_gnt         = '0;
    narrow_q_ready_o = '0;
    wide_q_ready_o   = '0;
    bank_q_valid_o   = '0;
    bank_q_o         = '0;
    for (int unsigned g = 0; g < NG; g++) begin
      contested[g] = wide_q_valid_i[g] && (|narrow_q_valid_i[g*F +: F]);
      if (ArbMode == 0)      wide_win[g] = 1'b0;
      else if (ArbMode == 1) wide_win[g] = 1'b1;
      else if (ArbMode == 2) wide_win[g] = rr_q[g];
      else                   wide_win[g] = (stall_q[g] == StallMax);
      wide_gnt[g]       = !rst_i && wide_q_valid_i[g] && (!contested[g] || wide_win[g]);
      wide_q_ready_o[g] = wide_gnt[g];
      for (int unsigned j = 0; j < F; j++) begin
        if (wide_gnt[g]) begin
          bank_q_valid_o[g*F+j] = 1'b1;
          bank_q_o[g*F+j]       = wide_q_i[g*F+j];
        end else if (!rst_i && narrow_q_valid_i[g*F+j]) begin
          narrow_q_ready_o[g*F+j] = 1'b1;
          bank_q_valid_o[g*F+j]   = 1'b1;
          bank_q_o[g*F+j]         = narrow_q_i[g*F+j];
        end
      end
    end
  end

  // Policy state moves only on contests (stall also clears on any wide grant).
  always_ff @(posedge clk_i) begin : policy_and_ownership
    if (rst_i) begin
      rr_q       <= '0;
      stall_q    <= '0;
      own_wide_q <= '0;
      own_mask_q <= '0;
    end else begin
      for (int unsigned g = 0; g < NG; g++) begin
        if (contested[g]) rr_q[g] <= !wide_gnt[g];
        if (wide_gnt[g]) begin
          stall_q[g] <= '0;
        end else if (contested[g] && (stall_q[g] != {SW{1'b1}})) begin
          stall_q[g] <= stall_q[g] + SW'(1);
        end
      end
      own_wide_q[0] <= wide_gnt;
      own_mask_q[0] <= bank_q_valid_o;
      for (int unsigned s = 1; s < BankLatency; s++) begin
        own_wide_q[s] <= own_wide_q[s-1];
        own_mask_q[s] <= own_mask_q[s-1];
      end
    end
  end

  // Route bank read data to whoever owned the bank BankLatency cycles ago.
  always_comb begin : steer_responses
    narrow_p_valid_o = '0;
    narrow_p_data_o  = '0;
    wide_p_valid_o   = '0;
    wide_p_data_o    = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (!rst_i && own_mask_q[BankLatency-1][i] && !own_wide_q[BankLatency-1][i/F]) begin
        narrow_p_valid_o[i] = 1'b1;
        narrow_p_data_o[i]  = bank_p_data_i[i];
      end
    end
    for (int unsigned g = 0; g < NG; g++) begin
      if (!rst_i && own_wide_q[BankLatency-1][g]) begin
        wide_p_valid_o[g] = 1'b1;
        for (int unsigned j = 0; j < F; j++) begin
          wide_p_data_o[g*F+j] = bank_p_data_i[g*F+j];
        end
      end
    end
  end

endmodule
